// File: rtl/fadd_arbiter.sv
// Round-robin arbiter sharing one pipelined float adder between two requesters.
// Tracks per-stage valid/tag bits so each sum returns on one tagged result channel.
module fadd_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic [1:0]  req0_rm,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  input  logic [1:0]  req1_rm,
  output logic [31:0] fa_a,
  output logic [31:0] fa_b,
  output logic        fa_sub,
  output logic [1:0]  fa_rm,
  output logic        fa_e,
  input  logic [31:0] fa_s,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_tag,
  output logic [31:0] res_data,
  output logic        busy
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] tag_q, tag_d;
  logic             ptr_q, ptr_d;   // 0 favours port 0 on contention
  logic             grant0, grant1;

  assign fa_e = ~(v_q[DEPTH-1] & ~res_ready);

  // Grant selection; masked during reset so no requester sees ready while clrn is low
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (clrn && fa_e) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~ptr_q;
        grant1 = ptr_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Operand mux; an ungranted cycle feeds an all-zero bubble into the adder
  always_comb begin
    fa_a   = 32'd0;
    fa_b   = 32'd0;
    fa_sub = 1'b0;
    fa_rm  = 2'd0;
    if (grant0) begin
      fa_a   = req0_a;
      fa_b   = req0_b;
      fa_sub = req0_sub;
      fa_rm  = req0_rm;
    end else if (grant1) begin
      fa_a   = req1_a;
      fa_b   = req1_b;
      fa_sub = req1_sub;
      fa_rm  = req1_rm;
    end else begin
      fa_a   = 32'd0;
      fa_b   = 32'd0;
      fa_sub = 1'b0;
      fa_rm  = 2'd0;
    end
  end

  // Next state: valid/tag shift and pointer flip, frozen together with the adder
  always_comb begin
    v_d   = v_q;
    tag_d = tag_q;
    ptr_d = ptr_q;
    if (fa_e) begin
      v_d[0]   = grant0 | grant1;
      tag_d[0] = grant1;
      for (int k = 1; k < DEPTH; k++) begin
        v_d[k]   = v_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
      if (req0_valid && req1_valid) begin
        ptr_d = ~ptr_q;
      end else begin
        ptr_d = ptr_q;
      end
    end else begin
      v_d   = v_q;
      tag_d = tag_q;
      ptr_d = ptr_q;
    end
  end

  // State registers; reset drops every in-flight operation
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v_q   <= '0;
      tag_q <= '0;
      ptr_q <= 1'b0;
    end else begin
      v_q   <= v_d;
      tag_q <= tag_d;
      ptr_q <= ptr_d;
    end
  end

  assign res_valid = v_q[DEPTH-1];
  assign res_tag   = tag_q[DEPTH-1];
  assign res_data  = fa_s;
  assign busy      = |v_q;

endmodule

// File: tb/tb_fadd_arbiter.sv
// Bench for fadd_arbiter: a stub pipelined adder, directed vector table,
// hand-written stall/reset sequences and a randomized scoreboard phase.
module tb_fadd_arbiter;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [1:0]  rm;
  } op_t;

  typedef struct {
    logic [2:0]  vvr;   // {v0, v1, res_ready}
    int          op0;
    int          op1;
    logic [5:0]  ex;    // {r0, r1, res_valid, res_tag, fa_e, busy}
    logic [31:0] d;
  } vec_t;

  logic        clk = 1'b0;
  logic        clrn;
  logic        req0_valid, req0_ready, req0_sub;
  logic [31:0] req0_a, req0_b;
  logic [1:0]  req0_rm;
  logic        req1_valid, req1_ready, req1_sub;
  logic [31:0] req1_a, req1_b;
  logic [1:0]  req1_rm;
  logic [31:0] fa_a, fa_b, fa_s;
  logic        fa_sub, fa_e;
  logic [1:0]  fa_rm;
  logic        res_valid, res_ready, res_tag, busy;
  logic [31:0] res_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fadd_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .clrn(clrn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sub(req0_sub), .req0_rm(req0_rm),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sub(req1_sub), .req1_rm(req1_rm),
    .fa_a(fa_a), .fa_b(fa_b), .fa_sub(fa_sub), .fa_rm(fa_rm), .fa_e(fa_e), .fa_s(fa_s),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_data(res_data),
    .busy(busy)
  );

  // Adder stand-in: exact IEEE results for the directed operands, a fixed scramble otherwise
  function automatic logic [31:0] fmodel(op_t o);
    if (o.a == 32'h3F800000 && o.b == 32'h40000000 && !o.sub) return 32'h40400000;
    if (o.a == 32'h40400000 && o.b == 32'h3F800000 && o.sub) return 32'h40000000;
    if (o.a == 32'h3F800000 && o.b == 32'h3F800000 && !o.sub) return 32'h40000000;
    return o.a ^ {o.b[15:0], o.b[31:16]} ^ {29'd0, o.rm, o.sub};
  endfunction

  function automatic op_t kop(int k);
    op_t o;
    case (k)
      0:       o = '{a: 32'h3F800000, b: 32'h40000000, sub: 1'b0, rm: 2'd0};
      1:       o = '{a: 32'h40400000, b: 32'h3F800000, sub: 1'b1, rm: 2'd0};
      default: o = '{a: 32'h3F800000, b: 32'h3F800000, sub: 1'b0, rm: 2'd0};
    endcase
    return o;
  endfunction

  op_t stg [DEPTH];
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
    end else if (fa_e) begin
      stg[0] <= {fa_a, fa_b, fa_sub, fa_rm};
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end
  assign fa_s = fmodel(stg[DEPTH-1]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input op_t o0, input logic v1, input op_t o1, input logic rr);
    req0_valid = v0; req0_a = o0.a; req0_b = o0.b; req0_sub = o0.sub; req0_rm = o0.rm;
    req1_valid = v1; req1_a = o1.a; req1_b = o1.b; req1_sub = o1.sub; req1_rm = o1.rm;
    res_ready  = rr;
  endtask

  function automatic vec_t mk(logic [2:0] vvr, int op0, int op1, logic [5:0] ex, logic [31:0] d);
    vec_t r;
    r.vvr = vvr; r.op0 = op0; r.op1 = op1; r.ex = ex; r.d = d;
    return r;
  endfunction

  vec_t tbl [24];
  op_t  bp [4];
  op_t  p0, p1;
  logic pv0, pv1, rr, eg0, eg1, efe, mptr;
  logic [DEPTH-1:0] mv, mt;
  logic [31:0] md [DEPTH];
  int   idx;
  logic [11:0] bp_r1  = 12'b0000_1100_0011;
  logic [11:0] bp_rv  = 12'b0011_1111_1100;
  logic [11:0] bp_fe  = 12'b1111_1100_0011;
  int   bp_di [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0};

  initial begin
    tbl[0]  = mk(3'b101, 0, 0, 6'b100010, 32'h0);
    tbl[1]  = mk(3'b001, 0, 0, 6'b000011, 32'h0);
    tbl[2]  = mk(3'b001, 0, 0, 6'b001011, 32'h40400000);
    tbl[3]  = mk(3'b001, 0, 0, 6'b000010, 32'h0);
    tbl[4]  = mk(3'b111, 1, 2, 6'b100010, 32'h0);
    tbl[5]  = mk(3'b111, 1, 2, 6'b010011, 32'h0);
    tbl[6]  = mk(3'b111, 1, 2, 6'b101011, 32'h40000000);
    tbl[7]  = mk(3'b111, 1, 2, 6'b011111, 32'h40000000);
    tbl[8]  = mk(3'b001, 0, 0, 6'b001011, 32'h40000000);
    tbl[9]  = mk(3'b001, 0, 0, 6'b001111, 32'h40000000);
    tbl[10] = mk(3'b001, 0, 0, 6'b000010, 32'h0);
    tbl[11] = mk(3'b011, 0, 2, 6'b010010, 32'h0);
    tbl[12] = mk(3'b011, 0, 2, 6'b010011, 32'h0);
    tbl[13] = mk(3'b011, 0, 2, 6'b011111, 32'h40000000);
    tbl[14] = mk(3'b111, 0, 2, 6'b101111, 32'h40000000);
    tbl[15] = mk(3'b001, 0, 0, 6'b001111, 32'h40000000);
    tbl[16] = mk(3'b001, 0, 0, 6'b001011, 32'h40400000);
    tbl[17] = mk(3'b001, 0, 0, 6'b000010, 32'h0);
    tbl[18] = mk(3'b101, 0, 0, 6'b100010, 32'h0);
    tbl[19] = mk(3'b001, 0, 0, 6'b000011, 32'h0);
    tbl[20] = mk(3'b101, 0, 0, 6'b101011, 32'h40400000);
    tbl[21] = mk(3'b001, 0, 0, 6'b000011, 32'h0);
    tbl[22] = mk(3'b001, 0, 0, 6'b001011, 32'h40400000);
    tbl[23] = mk(3'b001, 0, 0, 6'b000010, 32'h0);

    // Reset state, with a requester already valid
    clrn = 1'b0;
    drive(1'b1, kop(0), 1'b0, '0, 1'b1);
    @(negedge clk); @(negedge clk);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_fa_e", {31'd0, fa_e}, 32'd1);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    clrn = 1'b1;

    // Directed table: single op, contention, single-requester fairness, bubbles
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(tbl[i].vvr[2], tbl[i].vvr[2] ? kop(tbl[i].op0) : '0,
            tbl[i].vvr[1], tbl[i].vvr[1] ? kop(tbl[i].op1) : '0, tbl[i].vvr[0]);
      #1;
      chk($sformatf("t%0d_ready0", i), {31'd0, req0_ready}, {31'd0, tbl[i].ex[5]});
      chk($sformatf("t%0d_ready1", i), {31'd0, req1_ready}, {31'd0, tbl[i].ex[4]});
      chk($sformatf("t%0d_res_valid", i), {31'd0, res_valid}, {31'd0, tbl[i].ex[3]});
      chk($sformatf("t%0d_fa_e", i), {31'd0, fa_e}, {31'd0, tbl[i].ex[1]});
      chk($sformatf("t%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].ex[0]});
      if (tbl[i].ex[3]) begin
        chk($sformatf("t%0d_res_tag", i), {31'd0, res_tag}, {31'd0, tbl[i].ex[2]});
        chk($sformatf("t%0d_res_data", i), res_data, tbl[i].d);
      end
    end

    // Back-pressure: four port-1 ops, consumer stalls for cycles 2..5
    for (int k = 0; k < 4; k++)
      bp[k] = '{a: 32'h11110000 + k, b: 32'h00002222 * (k + 1), sub: k[0], rm: k[1:0]};
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      drive(1'b0, '0, idx < 4, (idx < 4) ? bp[idx] : '0, !(c >= 2 && c <= 5));
      #1;
      chk($sformatf("bp%0d_ready1", c), {31'd0, req1_ready}, {31'd0, bp_r1[c]});
      chk($sformatf("bp%0d_fa_e", c), {31'd0, fa_e}, {31'd0, bp_fe[c]});
      chk($sformatf("bp%0d_res_valid", c), {31'd0, res_valid}, {31'd0, bp_rv[c]});
      if (bp_rv[c]) begin
        chk($sformatf("bp%0d_res_tag", c), {31'd0, res_tag}, 32'd1);
        chk($sformatf("bp%0d_res_data", c), res_data, fmodel(bp[bp_di[c]]));
      end
      if (bp_r1[c]) idx++;
    end

    // Async reset with two ops in flight; pointer favours port 1 beforehand
    @(negedge clk); drive(1'b1, kop(0), 1'b1, kop(2), 1'b1); #1;
    chk("ar_pre_ready1", {30'd0, req0_ready, req1_ready}, 32'd1);
    @(negedge clk); drive(1'b1, kop(0), 1'b1, kop(2), 1'b1); #1;
    chk("ar_pre_ready0", {30'd0, req0_ready, req1_ready}, 32'd2);
    @(negedge clk); drive(1'b1, kop(0), 1'b1, kop(2), 1'b1); #1;
    chk("ar_inflight", {30'd0, res_valid, busy}, 32'd3);
    #1 clrn = 1'b0;
    #1;
    chk("ar_res_valid", {31'd0, res_valid}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_readys", {30'd0, req0_ready, req1_ready}, 32'd0);
    chk("ar_fa_e", {31'd0, fa_e}, 32'd1);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    clrn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk($sformatf("ar_post%0d", c), {30'd0, res_valid, busy}, 32'd0);
    end
    @(negedge clk); drive(1'b1, kop(0), 1'b1, kop(2), 1'b1); #1;
    chk("ar_ptr_reset", {30'd0, req0_ready, req1_ready}, 32'd2);

    // Randomized phase against a slot-array reference model
    @(negedge clk);
    clrn = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    #2 clrn = 1'b1;
    mv = '0; mt = '0; mptr = 1'b0;
    for (int k = 0; k < DEPTH; k++) md[k] = 32'd0;
    pv0 = 1'b0; pv1 = 1'b0; p0 = '0; p1 = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rr = ($urandom_range(0, 3) != 0);
      drive(pv0, p0, pv1, p1, rr);
      #1;
      efe = ~(mv[DEPTH-1] & ~rr);
      eg0 = efe & pv0 & (~pv1 | ~mptr);
      eg1 = efe & pv1 & (~pv0 | mptr);
      chk("rnd_ready0", {31'd0, req0_ready}, {31'd0, eg0});
      chk("rnd_ready1", {31'd0, req1_ready}, {31'd0, eg1});
      chk("rnd_fa_e", {31'd0, fa_e}, {31'd0, efe});
      chk("rnd_res_valid", {31'd0, res_valid}, {31'd0, mv[DEPTH-1]});
      chk("rnd_busy", {31'd0, busy}, {31'd0, |mv});
      if (mv[DEPTH-1]) begin
        chk("rnd_res_tag", {31'd0, res_tag}, {31'd0, mt[DEPTH-1]});
        chk("rnd_res_data", res_data, md[DEPTH-1]);
      end
      if (efe) begin
        for (int k = DEPTH - 1; k > 0; k--) begin
          mv[k] = mv[k-1]; mt[k] = mt[k-1]; md[k] = md[k-1];
        end
        mv[0] = eg0 | eg1;
        mt[0] = eg1;
        md[0] = eg1 ? fmodel(p1) : (eg0 ? fmodel(p0) : 32'd0);
        if (pv0 && pv1) mptr = ~mptr;
      end
      if (!pv0 || eg0) begin
        pv0 = ($urandom_range(0, 2) != 0);
        p0 = '{a: $urandom, b: $urandom, sub: 1'($urandom_range(0, 1)), rm: 2'($urandom_range(0, 3))};
      end
      if (!pv1 || eg1) begin
        pv1 = ($urandom_range(0, 2) != 0);
        p1 = '{a: $urandom, b: $urandom, sub: 1'($urandom_range(0, 1)), rm: 2'($urandom_range(0, 3))};
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
